// File: rtl/mna_irq_ctrl.sv
// Interrupt aggregator for NUM_CH DMA channels with an APB register file (RAW/ENABLE/MASKED/COAL_CFG).
// Define MNA_IRQ_COALESCE_EN to add done-interrupt coalescing (count threshold plus timeout).
module mna_irq_ctrl #(
    parameter int NUM_CH = 4
) (
    input  logic              i_apb_pclk,
    input  logic              i_apb_prstn,
    input  logic [NUM_CH-1:0] i_irq_done,
    input  logic [NUM_CH-1:0] i_irq_err,
    input  logic              i_apb_psel,
    input  logic              i_apb_penable,
    input  logic              i_apb_pwrite,
    input  logic [11:0]       i_apb_paddr,
    input  logic [31:0]       i_apb_pwdata,
    output logic [31:0]       o_apb_prdata,
    output logic [NUM_CH-1:0] o_irq_done,
    output logic [NUM_CH-1:0] o_irq_err,
    output logic              o_irq
);

    localparam logic [15:0] CH_MASK   = 16'((32'd1 << NUM_CH) - 32'd1);
    localparam logic [31:0] MAP_MASK  = {CH_MASK, CH_MASK};
    localparam logic [11:0] ADDR_RAW  = 12'h000;
    localparam logic [11:0] ADDR_EN   = 12'h004;
    localparam logic [11:0] ADDR_MSK  = 12'h008;
    localparam logic [11:0] ADDR_COAL = 12'h00C;

    logic [31:0]       src, prev_q, set_ev, w1c;
    logic [31:0]       raw_q, raw_d, en_q, en_d, masked;
    logic [31:0]       coal_rd;
    logic              armed_q;
    logic              wr_en;
    logic [NUM_CH-1:0] irq_done_q, irq_err_q;
    logic              irq_q, irq_d;

    // Done sources occupy bits [NUM_CH-1:0], err sources bits [16 +: NUM_CH].
    always_comb begin
        src                = '0;
        src[NUM_CH-1:0]    = i_irq_done;
        src[16 +: NUM_CH]  = i_irq_err;
    end

    // armed_q blocks edge detection on the first cycle after reset so that
    // sources already high at release only load prev_q.
    assign set_ev = armed_q ? (src & ~prev_q & MAP_MASK) : '0;
    assign wr_en  = i_apb_psel & i_apb_penable & i_apb_pwrite;
    assign w1c    = (wr_en && i_apb_paddr == ADDR_RAW) ? i_apb_pwdata : '0;
    assign raw_d  = ((raw_q & ~w1c) | set_ev) & MAP_MASK;
    assign en_d   = (wr_en && i_apb_paddr == ADDR_EN) ? (i_apb_pwdata & MAP_MASK) : en_q;
    assign masked = raw_q & en_q;

`ifdef MNA_IRQ_COALESCE_EN
    logic [23:0] coal_q, coal_d;
    logic [7:0]  cnt_q, cnt_d, thr;
    logic [15:0] tmr_q, tmr_d, tmo;
    logic        fire_q, fire_d, fire_c;
    logic [4:0]  new_cnt;
    logic [8:0]  sum;

    always_comb begin
        coal_d  = (wr_en && i_apb_paddr == ADDR_COAL) ? i_apb_pwdata[23:0] : coal_q;
        thr     = (coal_q[7:0] == 8'd0) ? 8'd1 : coal_q[7:0];
        tmo     = coal_q[23:8];
        new_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            new_cnt = new_cnt + 5'(set_ev[i] & en_q[i]);
        end
        sum    = {1'b0, cnt_q} + {4'b0, new_cnt};
        fire_c = fire_q | (cnt_q >= thr) |
                 ((tmo != 16'd0) && (cnt_q != 8'd0) && (tmr_q == tmo));
        // Once no masked done bit remains the window closes; events arriving in
        // that same cycle open the next window.
        if (masked[NUM_CH-1:0] == '0) begin
            cnt_d  = {3'b0, new_cnt};
            tmr_d  = '0;
            fire_d = 1'b0;
        end else begin
            cnt_d  = sum[8] ? 8'hFF : sum[7:0];
            tmr_d  = (cnt_q == 8'd0) ? 16'd0 :
                     (tmr_q == 16'hFFFF) ? tmr_q : tmr_q + 16'd1;
            fire_d = fire_c;
        end
        irq_d   = (|masked[16 +: NUM_CH]) | (fire_c & (|masked[NUM_CH-1:0]));
        coal_rd = {8'b0, coal_q};
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_prstn) begin
        if (!i_apb_prstn) begin
            coal_q <= '0;
            cnt_q  <= '0;
            tmr_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            coal_q <= coal_d;
            cnt_q  <= cnt_d;
            tmr_q  <= tmr_d;
            fire_q <= fire_d;
        end
    end
`else
    assign irq_d   = |masked;
    assign coal_rd = '0;
`endif

    always_comb begin
        o_apb_prdata = '0;
        if (i_apb_psel && !i_apb_pwrite) begin
            case (i_apb_paddr)
                ADDR_RAW:  o_apb_prdata = raw_q;
                ADDR_EN:   o_apb_prdata = en_q;
                ADDR_MSK:  o_apb_prdata = masked;
                ADDR_COAL: o_apb_prdata = coal_rd;
                default:   o_apb_prdata = '0;
            endcase
        end
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_prstn) begin
        if (!i_apb_prstn) begin
            prev_q     <= '0;
            armed_q    <= 1'b0;
            raw_q      <= '0;
            en_q       <= '0;
            irq_done_q <= '0;
            irq_err_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= src;
            armed_q    <= 1'b1;
            raw_q      <= raw_d;
            en_q       <= en_d;
            irq_done_q <= masked[NUM_CH-1:0];
            irq_err_q  <= masked[16 +: NUM_CH];
            irq_q      <= irq_d;
        end
    end

    assign o_irq_done = irq_done_q;
    assign o_irq_err  = irq_err_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_mna_irq_ctrl.sv
// Self-checking bench for mna_irq_ctrl; coalescing scenarios run when MNA_IRQ_COALESCE_EN is defined.
module tb_mna_irq_ctrl;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] done = '0, err = '0;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0]       paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic [NUM_CH-1:0] o_done, o_err;
    logic              o_irq;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    mna_irq_ctrl #(.NUM_CH(NUM_CH)) dut (
        .i_apb_pclk    (clk),
        .i_apb_prstn   (rst_n),
        .i_irq_done    (done),
        .i_irq_err     (err),
        .i_apb_psel    (psel),
        .i_apb_penable (penable),
        .i_apb_pwrite  (pwrite),
        .i_apb_paddr   (paddr),
        .i_apb_pwdata  (pwdata),
        .o_apb_prdata  (prdata),
        .o_irq_done    (o_done),
        .o_irq_err     (o_err),
        .o_irq         (o_irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking / scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [NUM_CH-1:0] d, input logic [NUM_CH-1:0] e,
                                         input logic i);
        pack              = '0;
        pack[NUM_CH-1:0]  = d;
        pack[16 +: NUM_CH] = e;
        pack[31]          = i;
    endfunction

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check_out(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, pack(o_done, o_err, o_irq), e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0;
    endtask

    task automatic sb_check_reg(input string tag, input logic [11:0] a);
        logic [31:0] d, e;
        apb_read(a, d);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, d, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] en_r;
        logic [NUM_CH-1:0] d, e;
        int n;

        // Reset state
        tick(); tick();
        sb_push(pack('0, '0, 1'b0)); sb_check_out("rst_out");
        sb_push(32'h0); sb_check_reg("rst_raw", 12'h000);
        sb_push(32'h0); sb_check_reg("rst_en", 12'h004);
        rst_n = 1'b1;
        tick();

        // Single done pulse, latency and W1C
        apb_write(12'h004, 32'h0001000F);
        sb_push(32'h0001000F); sb_check_reg("en_rb", 12'h004);
        done[2] = 1'b1;
        sb_push(32'h4);
        sb_push(pack('0, '0, 1'b0));
        sb_push(pack(4'h4, '0, 1'b1));
        tick();
        done[2] = 1'b0;
        sb_check_reg("raw_set", 12'h000);
        sb_check_out("out_1edge");
        tick();
        sb_check_out("out_2edge");
        sb_push(32'h4); sb_check_reg("masked", 12'h008);
        apb_write(12'h000, 32'h4);
        sb_push(32'h0); sb_check_reg("raw_w1c", 12'h000);
        tick();
        sb_push(pack('0, '0, 1'b0)); sb_check_out("out_w1c");

        // Set wins over W1C in the same cycle; held level sets only once
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 12'h000; pwdata = 32'h00020000;
        tick();
        penable = 1'b1; err[1] = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        sb_push(32'h00020000); sb_check_reg("set_wins", 12'h000);
        apb_write(12'h000, 32'h00020000);
        tick(); tick(); tick();
        sb_push(32'h0); sb_check_reg("held_no_reset", 12'h000);
        err[1] = 1'b0;
        tick();

        // Unmapped address and COAL_CFG
        apb_write(12'h010, 32'hFFFFFFFF);
        sb_push(32'h0); sb_check_reg("unmapped_rd", 12'h010);
        sb_push(32'h0001000F); sb_check_reg("unmapped_en", 12'h004);
        apb_write(12'h00C, 32'hFF123456);
`ifdef MNA_IRQ_COALESCE_EN
        sb_push(32'h00123456);
`else
        sb_push(32'h0);
`endif
        sb_check_reg("coal_cfg", 12'h00C);
        apb_write(12'h00C, 32'h0);

        // Sources raised while disabled, then enabled
        apb_write(12'h004, 32'h0);
        done = '1; err = '1;
        tick(); tick();
        sb_push(32'h000F000F); sb_check_reg("raw_all", 12'h000);
        sb_push(32'h0); sb_check_reg("masked_dis", 12'h008);
        sb_push(pack('0, '0, 1'b0)); sb_check_out("out_dis");
        apb_write(12'h004, 32'hFFFFFFFF);
        sb_push(32'h000F000F); sb_check_reg("en_clip", 12'h004);
        tick();
        sb_push(pack('1, '1, 1'b1)); sb_check_out("out_en_all");
        apb_write(12'h004, 32'h000F0000);
        tick();
        sb_push(pack('0, '1, 1'b1)); sb_check_out("out_done_dis");
        sb_push(32'h000F000F); sb_check_reg("raw_kept", 12'h000);
        done = '0; err = '0;
        apb_write(12'h004, 32'h0);
        apb_write(12'h000, 32'hFFFFFFFF);
        tick();

        // Random pulses against the scoreboard
        for (int it = 0; it < 16; it++) begin
            en_r = $urandom;
            apb_write(12'h004, en_r);
            d = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            e = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            done = d; err = e;
            sb_push(pack(d, e, 1'b0) & 32'h7FFFFFFF);
            sb_push(pack(d & en_r[NUM_CH-1:0], e & en_r[16 +: NUM_CH],
                         |{d & en_r[NUM_CH-1:0], e & en_r[16 +: NUM_CH]}));
            tick();
            done = '0; err = '0;
            sb_check_reg($sformatf("rnd_raw_%0d", it), 12'h000);
            tick();
            sb_check_out($sformatf("rnd_out_%0d", it));
            apb_write(12'h000, 32'hFFFFFFFF);
            tick();
        end

`ifdef MNA_IRQ_COALESCE_EN
        // Threshold 3, no timeout
        apb_write(12'h004, 32'h000F000F);
        apb_write(12'h00C, 32'h00000003);
        for (int ch = 0; ch < 3; ch++) begin
            done[ch] = 1'b1;
            tick();
            done[ch] = 1'b0;
            tick();
            sb_push(pack(NUM_CH'((1 << (ch + 1)) - 1), '0, ch == 2));
            sb_check_out($sformatf("coal_thr_ch%0d", ch));
            tick();
        end
        apb_write(12'h000, 32'h0000000F);
        tick();
        sb_push(pack('0, '0, 1'b0)); sb_check_out("coal_clear");
        done[3] = 1'b1;
        tick();
        done[3] = 1'b0;
        tick(); tick();
        sb_push(pack(4'h8, '0, 1'b0)); sb_check_out("coal_cnt_reset");
        apb_write(12'h000, 32'hFFFFFFFF);
        tick();

        // Threshold 8, timeout 20
        apb_write(12'h00C, 32'h00001408);
        done[0] = 1'b1;
        sb_push(32'd21);
        tick();
        done[0] = 1'b0;
        n = 0;
        while (!o_irq && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check_eq("coal_timeout", 32'(n), exp_q.pop_front());
        apb_write(12'h000, 32'hFFFFFFFF);
        tick();
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        err[0] = 1'b1;
        sb_push(pack(4'h1, '0, 1'b0));
        sb_push(pack(4'h1, 4'h1, 1'b1));
        tick();
        err[0] = 1'b0;
        sb_check_out("coal_err_pre");
        tick();
        sb_check_out("coal_err_now");
        apb_write(12'h000, 32'hFFFFFFFF);
        apb_write(12'h00C, 32'h0);
        tick();
`endif

        // Asynchronous reset with state set and sources held high
        apb_write(12'h004, 32'h0000000F);
        done = '1;
        tick(); tick();
        sb_push(pack('1, '0, 1'b1)); sb_check_out("pre_rst_out");
        #2;
        rst_n = 1'b0;
        #1;
        sb_push(pack('0, '0, 1'b0)); sb_check_out("async_rst_out");
        sb_push(32'h0); sb_check_reg("async_rst_raw", 12'h000);
        sb_push(32'h0); sb_check_reg("async_rst_en", 12'h004);
        sb_push(32'h0); sb_check_reg("async_rst_coal", 12'h00C);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        sb_push(32'h0); sb_check_reg("rel_high_raw", 12'h000);
        done = '0;
        tick();
        sb_push(32'h0); sb_check_reg("rel_fall_raw", 12'h000);
        sb_push(pack('0, '0, 1'b0)); sb_check_out("rel_out");

        if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mna_irq_ctrl.md
MNA_IRQ_CTRL -- requirements
Module: mna_irq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of DMA channels (legal range 1..16); each channel has one done source and one err source.
REQ-002 i_apb_pclk  in  1  single clock for all logic.
REQ-003 i_apb_prstn  in  1  asynchronous active-low reset.
REQ-004 i_irq_done  in  NUM_CH  per-channel done level from DMA.
REQ-005 i_irq_err  in  NUM_CH  per-channel error level from DMA.
REQ-006 i_apb_psel, i_apb_penable, i_apb_pwrite  in  1 each  APB control.
REQ-007 i_apb_paddr  in  12  APB byte address; i_apb_pwdata  in  32  APB write data.
REQ-008 o_apb_prdata  out  32  APB read data; zero wait states, no pready.
REQ-009 o_irq_done, o_irq_err  out  NUM_CH each  masked per-channel interrupts.
REQ-010 o_irq  out  1  combined interrupt.

Function
REQ-011 Register map: 0x000 RAW (W1C), 0x004 ENABLE (RW), 0x008 MASKED (RO, RAW&ENABLE), 0x00C COAL_CFG (RW); bit i = done ch i, bit 16+i = err ch i; bits not mapped read 0, writes ignored.
REQ-012 Write occurs on the cycle with psel=1, penable=1, pwrite=1; unmapped addresses are ignored.
REQ-013 o_apb_prdata is combinational from paddr when psel=1 and pwrite=0, otherwise 0.
REQ-014 Each source has a previous-value register; a RAW bit sets on the clock edge where source=1 and previous=0; level-held sources set the bit once.
REQ-015 Writing 1 to a RAW bit clears it; writing 0 has no effect.
REQ-016 A set event and a W1C clear of the same bit in the same cycle: set wins, bit remains 1.
REQ-017 o_irq_done[i], o_irq_err[i] are registered from MASKED; they assert one cycle after the RAW bit sets, so two edges after the source rises.
REQ-018 Without coalescing, o_irq is registered OR of all MASKED bits, same latency as REQ-017.
REQ-019 Disabling an ENABLE bit leaves the RAW bit intact and drops the corresponding output on the next edge.

Reset
REQ-020 On i_apb_prstn low: RAW, ENABLE, COAL_CFG, previous-value registers, counters, timer and all outputs go to 0 asynchronously.
REQ-021 Sources already high when reset releases do not set RAW, because the previous-value registers capture the level first.

Configuration
REQ-022 With MNA_IRQ_COALESCE_EN defined, COAL_CFG holds threshold [7:0] and timeout [23:8]; a threshold of 0 is treated as 1, and a timeout of 0 disables the timer.
REQ-023 Coalescing counter: adds the number of newly set, enabled done bits each cycle (multiple channels in the same cycle are counted individually), saturates at 255.
REQ-024 Timer: starts on the first counted event while count=0 and increments every cycle.
REQ-025 Fire: sets fire when count>=threshold or timer==timeout (timeout≠0).
REQ-026 Combined interrupt: o_irq = registered (OR of MASKED err bits) | (fire & OR of MASKED done bits); err bits are never delayed.
REQ-027 Counter, timer and fire clear on the edge after all MASKED done bits are 0.
REQ-028 Per-channel outputs are unaffected by coalescing.
REQ-029 Without MNA_IRQ_COALESCE_EN, COAL_CFG reads 0, writes are ignored, and REQ-018 applies.

Verification
REQ-030 ENABLE=0x0001000F; pulse i_irq_done[2] for 1 cycle -> RAW=0x4, o_irq_done[2] and o_irq high 2 edges after the rise; W1C 0x4 -> both low on the following edge.
REQ-031 i_irq_err[1] held high while software writes W1C 0x20000 in the bit-set cycle -> RAW bit 17 stays 1; no re-set occurs while the source is held.
REQ-032 ENABLE=0; raise all sources -> RAW=0x000F000F, MASKED=0, all outputs 0; then ENABLE=0xFFFFFFFF -> outputs assert on the next edge and ENABLE reads back 0x000F000F.
REQ-033 (MNA_IRQ_COALESCE_EN) threshold=3, timeout=0; done ch0 then ch1 -> o_irq=0; done ch2 -> o_irq=1; clear all done bits -> o_irq=0, count=0.
REQ-034 (MNA_IRQ_COALESCE_EN) threshold=8, timeout=20; one done event -> o_irq rises at timer 20; an err event mid-window -> o_irq high immediately.
REQ-035 Reset asserted with RAW=0xF, fire set -> all outputs and registers 0 immediately; sources high at release -> RAW stays 0.
